// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with run-time bounds, step and mode
// (wrap-up, wrap-down, bounce, hold), plus parallel load, terminal count and bound error.
module param_updown_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             ld_dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             tc,
  output logic             err
);

  localparam logic [1:0] MODE_WRAP_UP = 2'b00;
  localparam logic [1:0] MODE_WRAP_DN = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  // One extra bit on both sums so a step past the top of the range saturates
  // at the bound instead of wrapping silently.
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   lo_sum;
  logic [WIDTH-1:0] up_nxt;
  logic [WIDTH-1:0] dn_nxt;
  logic [WIDTH-1:0] bnc_nxt;
  logic             step_ok;

  assign err     = (lo > hi);
  assign up_sum  = {1'b0, cnt_q} + {1'b0, step};
  assign lo_sum  = {1'b0, lo} + {1'b0, step};
  assign up_nxt  = (up_sum > {1'b0, hi}) ? hi : up_sum[WIDTH-1:0];
  assign dn_nxt  = ({1'b0, cnt_q} < lo_sum) ? lo : (cnt_q - step);
  assign bnc_nxt = dir_q ? dn_nxt : up_nxt;
  assign step_ok = en && !err && (mode != MODE_HOLD);

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (ld) begin
      cnt_d = ld_val;
      dir_d = ld_dir;
    end else if (step_ok) begin
      // An out-of-range count is pulled back to the nearest bound first;
      // that cycle is spent on the clamp alone.
      if (cnt_q < lo) begin
        cnt_d = lo;
      end else if (cnt_q > hi) begin
        cnt_d = hi;
      end else if (step == '0) begin
        if (mode == MODE_WRAP_UP) dir_d = 1'b0;
        if (mode == MODE_WRAP_DN) dir_d = 1'b1;
      end else begin
        case (mode)
          MODE_WRAP_UP: begin
            dir_d = 1'b0;
            if (cnt_q == hi) begin
              cnt_d = lo;
            end else begin
              cnt_d = up_nxt;
              tc_d  = (up_nxt == hi);
            end
          end
          MODE_WRAP_DN: begin
            dir_d = 1'b1;
            if (cnt_q == lo) begin
              cnt_d = hi;
            end else begin
              cnt_d = dn_nxt;
              tc_d  = (dn_nxt == lo);
            end
          end
          MODE_BOUNCE: begin
            // Reaching the bound of travel turns around in the same cycle;
            // with lo==hi this toggles dir and pulses tc on every step.
            cnt_d = bnc_nxt;
            if (dir_q ? (bnc_nxt == lo) : (bnc_nxt == hi)) begin
              dir_d = ~dir_q;
              tc_d  = 1'b1;
            end
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt = cnt_q;
  assign dir = dir_q;
  assign tc  = tc_q;

endmodule
